// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// registered read port with valid strobe, and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             rd_acc;
    logic             wr_acc;

    // Flags come from the registered count only, never from pointer compares.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == FULL_CNT);
        almost_full  = (count_q >= AF_CNT);
        almost_empty = (count_q <= AE_CNT);
        count        = count_q;
        rd_acc       = rd_en && !empty;
        wr_acc       = wr_en && (!full || rd_acc);
    end

    // Storage is deliberately unreset; empty gates every read of stale contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // A new error event outranks a simultaneous clear.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous FIFO, the next generation of the team's single-clock buffer. Adds configurable width and depth, a live occupancy count, programmable almost-full and almost-empty thresholds, a read-valid strobe, full-with-read pass-through, and sticky overflow/underflow error flags. Sits between a producer and consumer in the same clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, 14, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- AW = $clog2(DEPTH), derived localparam; pointers are AW bits, count is AW+1 bits
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- wr_data  input  WIDTH  write data, sampled with an accepted write
- rd_en  input  1  read request
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  one-cycle pulse: rd_data holds a newly read word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was rejected
- underflow  output  1  sticky: a read was rejected
- err_clr  input  1  synchronous clear of overflow and underflow

## Operation
- rd_acc = rd_en && !empty; wr_acc = wr_en && (!full || rd_acc).
- Accepted write: mem[wr_ptr] ← wr_data, wr_ptr ← wr_ptr+1 (mod DEPTH).
- Accepted read: rd_data ← mem[rd_ptr], rd_ptr ← rd_ptr+1 (mod DEPTH), rd_valid ← 1; otherwise rd_valid ← 0 and rd_data holds.
- Full with rd_en and wr_en both high: both accepted, count stays DEPTH, oldest word read, new word written into the freed slot (the same address).
- Empty with rd_en and wr_en both high: write accepted, read rejected (no bypass); count becomes 1; underflow sets.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- overflow sets on wr_en && !wr_acc; underflow sets on rd_en && !rd_acc. err_clr clears both; a set event in the same cycle as err_clr wins (flag stays 1).
- Pointer wrap: natural AW-bit rollover; full/empty derive from count, never from pointer comparison.
- Memory array is not reset; contents after reset are undefined and never observable, because empty blocks reads.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1 (AE_LEVEL ≥ 0), almost_full=0.
- Reset asserted mid-operation discards all contents immediately; the first accepted write after release lands at address 0.
- full/empty/almost_*/count are combinational from the registered count: they change in the cycle after the accepting edge.
- Read latency: 1 cycle; rd_data and rd_valid update on the edge that accepts the read.
- Write-to-read latency: a word written at edge N is readable at edge N+1 at the earliest (rd_valid at N+1).
- Throughput: one write and one read per cycle sustained at any occupancy.

## Test plan
- Reset then write 16 words 0x00..0x0F with DEPTH=16 -> count 1..16, almost_full at count 14, full at 16; 17th write rejected, overflow=1, count stays 16.
- Read 16 words from full -> rd_data 0x00..0x0F in order, each with rd_valid pulse one cycle after rd_en; empty at end; extra rd_en -> underflow=1, rd_valid=0, rd_data stays 0x0F.
- Full FIFO, wr_en+rd_en together with wr_data=0xA5 -> rd_data=oldest word, count stays 16, no overflow; 0xA5 emerges last after 16 further reads.
- Empty FIFO, wr_en+rd_en with 0x3C -> count=1, underflow=1, no rd_valid; next-cycle read returns 0x3C.
- Write 40 / read 40 interleaved randomly (including both-high cycles) -> order preserved across pointer wrap, count matches reference model every cycle.
- Set overflow, pulse err_clr -> overflow=0; err_clr coincident with rejected write -> overflow stays 1; rst_n pulse mid-stream with count=9 -> all outputs at reset values in the same cycle.
